// File: rtl/mskaes_sharing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_sharing_pkg
// Purpose  : Shared FSM state type and sizing/index helpers for input sharing.
// Revision : 1.0 - initial release
// ============================================================================
package mskaes_sharing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    // Random beats needed to mask plaintext and key; zero when unshared.
    function automatic int nb_beats(input int nd, input int rnd_w);
        if (nd <= 1) return 0;
        return (256 * (nd - 1) + rnd_w - 1) / rnd_w;
    endfunction

    function automatic int cnt_width(input int nb);
        if (nb <= 2) return 1;
        return $clog2(nb);
    endfunction

    // Mask-buffer position feeding share j (1..nd-1) of bit i.
    function automatic int share_idx(input int nd, input int i, input int j);
        return (nd - 1) * i + (j - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mskaes_rnd_collector.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_rnd_collector
// Purpose  : Shifts random beats into a mask buffer and counts them.
// Revision : 1.0 - initial release
// ============================================================================
module mskaes_rnd_collector
    import mskaes_sharing_pkg::*;
#(
    parameter int d     = 2,
    parameter int RND_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      beat_en,
    input  logic [RND_W-1:0]          rnd_in,
    output logic                      beat_last,
    output logic [256*(d-1)-1:0]      mask_next
);

    localparam int NB     = nb_beats(d, RND_W);
    localparam int BUF_W  = NB * RND_W;
    localparam int MASK_W = 256 * (d - 1);
    localparam int CW     = cnt_width(NB);

    logic [BUF_W-1:0] r_buf;
    logic [BUF_W-1:0] w_buf_shift;
    logic [CW-1:0]    r_cnt;

    // New beats enter at the top so the first beat ends up in the lowest bits.
    generate
        if (NB == 1) begin : g_single
            assign w_buf_shift = rnd_in;
        end else begin : g_shift
            assign w_buf_shift = {rnd_in, r_buf[BUF_W-1:RND_W]};
        end
    endgenerate

    assign beat_last = beat_en && (r_cnt == CW'(NB - 1));
    assign mask_next = w_buf_shift[MASK_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (beat_en) begin
            if (beat_last) begin
                r_buf <= '0;
                r_cnt <= '0;
            end else begin
                r_buf <= w_buf_shift;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mskaes_input_sharer.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_input_sharer
// Purpose  : Splits unmasked plaintext/key into d Boolean shares.
// Revision : 1.0 - initial release
// ============================================================================
module mskaes_input_sharer
    import mskaes_sharing_pkg::*;
#(
    parameter int d     = 2,
    parameter int RND_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         plaintext,
    input  logic [127:0]         key,
    input  logic [RND_W-1:0]     rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [128*d-1:0]     sh_plaintext,
    output logic [128*d-1:0]     sh_key,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NB     = nb_beats(d, RND_W);
    localparam int MASK_W = (d > 1) ? 256 * (d - 1) : 1;
    localparam int PT_MW  = 128 * (d - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [127:0]       r_pt;
    logic [127:0]       r_key;
    logic [127:0]       w_src_pt;
    logic [127:0]       w_src_key;
    logic [128*d-1:0]   r_sh_pt;
    logic [128*d-1:0]   r_sh_key;
    logic [128*d-1:0]   w_sh_pt;
    logic [128*d-1:0]   w_sh_key;
    logic [MASK_W-1:0]  w_mask;
    logic               w_accept;
    logic               w_beat_en;
    logic               w_beat_last;
    logic               w_acc_pt;
    logic               w_acc_key;

    assign in_ready     = (r_state == ST_IDLE)    && !rst;
    assign rnd_ready    = (r_state == ST_COLLECT) && !rst;
    assign out_valid    = (r_state == ST_OUT)     && !rst;
    assign sh_plaintext = r_sh_pt;
    assign sh_key       = r_sh_key;
    assign w_accept     = in_valid && in_ready;
    assign w_beat_en    = rnd_valid && rnd_ready;

    generate
        if (NB > 0) begin : g_collect
            mskaes_rnd_collector #(
                .d     (d),
                .RND_W (RND_W)
            ) u_collector (
                .clk       (clk),
                .rst       (rst),
                .beat_en   (w_beat_en),
                .rnd_in    (rnd_in),
                .beat_last (w_beat_last),
                .mask_next (w_mask)
            );
            assign w_src_pt  = r_pt;
            assign w_src_key = r_key;
        end else begin : g_direct
            // Unshared: data passes straight to the share registers on accept.
            assign w_mask      = '0;
            assign w_beat_last = 1'b0;
            assign w_src_pt    = plaintext;
            assign w_src_key   = key;
        end
    endgenerate

    always_comb begin
        w_sh_pt   = '0;
        w_sh_key  = '0;
        w_acc_pt  = 1'b0;
        w_acc_key = 1'b0;
        for (int i = 0; i < 128; i++) begin
            w_acc_pt  = w_src_pt[i];
            w_acc_key = w_src_key[i];
            for (int j = 1; j < d; j++) begin
                w_sh_pt[d*i+j]  = w_mask[share_idx(d, i, j)];
                w_sh_key[d*i+j] = w_mask[PT_MW + share_idx(d, i, j)];
                w_acc_pt        = w_acc_pt  ^ w_mask[share_idx(d, i, j)];
                w_acc_key       = w_acc_key ^ w_mask[PT_MW + share_idx(d, i, j)];
            end
            w_sh_pt[d*i]  = w_acc_pt;
            w_sh_key[d*i] = w_acc_key;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept)    w_state_next = (NB == 0) ? ST_OUT : ST_COLLECT;
            ST_COLLECT: if (w_beat_last) w_state_next = ST_OUT;
            ST_OUT:     if (out_ready)   w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Unmasked copies live only between accept and the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pt     <= '0;
            r_key    <= '0;
            r_sh_pt  <= '0;
            r_sh_key <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (NB == 0) begin
                            r_sh_pt  <= w_sh_pt;
                            r_sh_key <= w_sh_key;
                        end else begin
                            r_pt  <= plaintext;
                            r_key <= key;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_beat_last) begin
                        r_sh_pt  <= w_sh_pt;
                        r_sh_key <= w_sh_key;
                        r_pt     <= '0;
                        r_key    <= '0;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_sh_pt  <= '0;
                        r_sh_key <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
